// File: rtl/pulso_sched_pkg.sv
// Shared types and constants for the pulso_sched delay-timer scheduler.
package pulso_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF = 18;
  localparam int unsigned MAX_REQ   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the set bit in a one-hot (or zero) vector of up to MAX_REQ bits.
  function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pulso_sched_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface pulso_sched_if
  import pulso_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic [N_REQ-1:0]       Req;
  logic [N_REQ*CNT_W-1:0] Delay;
  logic [N_REQ-1:0]       Grant;
  logic [N_REQ-1:0]       Done;
  logic                   Mo;
  logic                   Busy;

  modport master (output Req, output Delay, input Grant, input Done, input Mo, input Busy);
  modport slave  (input Req, input Delay, output Grant, output Done, output Mo, output Busy);
endinterface

// File: rtl/pulso_sched_rr_arbiter.sv
// Combinational round-robin arbiter; PULSO_SCHED_FIXED_PRIO_EN turns it into
// fixed priority (lowest index wins, pointer ignored).
module rr_arbiter
  import pulso_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_c_o,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             any_req_c_o
);

  logic [IDX_W-1:0] start_c;

`ifdef PULSO_SCHED_FIXED_PRIO_EN
  assign start_c = '0;
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`else
  assign start_c = ptr_i;
`endif

  // First requester at or above the start index, wrapping at N_REQ.
  always_comb begin
    int unsigned pos;
    pos     = 0;
    gnt_c_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(start_c) + k) % N_REQ;
      if ((gnt_c_o == '0) && req_i[IDX_W'(pos)]) gnt_c_o[IDX_W'(pos)] = 1'b1;
    end
  end

  assign idx_c_o     = IDX_W'(onehot_idx(MAX_REQ'(gnt_c_o)));
  assign any_req_c_o = |req_i;

endmodule

// File: rtl/pulso_sched.sv
// Shared delay-timer scheduler: one down-counter granted to requesters in turn.
// Build option PULSO_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module pulso_sched
  import pulso_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  pulso_sched_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               mo_q, mo_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   win_q, win_d;

  logic [N_REQ-1:0]   arb_gnt_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;
  logic [CNT_W-1:0]   arb_dly_c;
  logic [IDX_W-1:0]   ptr_c;
  logic [IDX_W-1:0]   ptr_nxt_c;
  logic               ptr_adv_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i       (bus.Req),
    .ptr_i       (ptr_c),
    .gnt_c_o     (arb_gnt_c),
    .idx_c_o     (arb_idx_c),
    .any_req_c_o (arb_any_c)
  );

  // Delay slice of the current arbitration winner.
  always_comb begin
    arb_dly_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt_c[i]) arb_dly_c = bus.Delay[i*CNT_W +: CNT_W];
    end
  end

  assign ptr_nxt_c = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);

`ifndef PULSO_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge Clk) begin
    if (Rst)            ptr_q <= '0;
    else if (ptr_adv_c) ptr_q <= ptr_nxt_c;
  end

  assign ptr_c = ptr_q;
`else
  assign ptr_c = '0;
  logic unused_ptr;
  assign unused_ptr = ptr_adv_c ^ (|ptr_nxt_c);
`endif

  // Abort (requester dropped Req) takes precedence over completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    win_d     = win_q;
    ptr_adv_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          grant_d = arb_gnt_c;
          win_d   = arb_idx_c;
          cnt_d   = arb_dly_c;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.Req[win_q]) begin
          grant_d   = '0;
          ptr_adv_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == '0) begin
          grant_d = '0;
          done_d  = grant_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        ptr_adv_c = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    mo_d   = |done_d;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      mo_q    <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      mo_q    <= mo_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
    end
  end

  assign bus.Grant = grant_q;
  assign bus.Done  = done_q;
  assign bus.Mo    = mo_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_pulso_sched.sv
// Bench for pulso_sched: timeline model compared every cycle plus directed literal checks.
module tb_pulso_sched;

  localparam int N = 4;
  localparam int W = 18;

  logic Clk;
  logic Rst;

  pulso_sched_if #(.N_REQ(N), .CNT_W(W)) bus ();

  pulso_sched #(.N_REQ(N), .CNT_W(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each grant is a window of cycles derived from the timing rules.
  int cyc      = 0;
  int g_start  = -1;
  int g_end    = -2;
  int b_end    = -2;
  int done_cyc = -1;
  int idle_from = 0;
  int m_w      = 0;
  int m_ptr    = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(negedge Clk) begin
    logic [N-1:0] eg, ed;
    logic         eb;
    int           d, w;
    eg = (cyc >= g_start && cyc <= g_end) ? N'(1 << m_w) : '0;
    ed = (cyc == done_cyc) ? N'(1 << m_w) : '0;
    eb = (cyc >= g_start && cyc <= b_end);
    check("grant", 32'(bus.Grant), 32'(eg));
    check("done",  32'(bus.Done),  32'(ed));
    check("mo",    32'(bus.Mo),    32'(|ed));
    check("busy",  32'(bus.Busy),  32'(eb));
    check("onehot", {29'd0, $onehot0(bus.Grant), $onehot0(bus.Done), ((bus.Grant & bus.Done) == '0)}, 32'd7);
    if (Rst) begin
      g_start = -1; g_end = -2; b_end = -2; done_cyc = -1;
      idle_from = cyc + 1; m_ptr = 0;
    end else if (cyc >= idle_from) begin
      if (bus.Req != '0) begin
`ifdef PULSO_SCHED_FIXED_PRIO_EN
        w = pick(bus.Req, 0);
`else
        w = pick(bus.Req, m_ptr);
`endif
        d = int'(bus.Delay[w*W +: W]);
        m_w = w;
        g_start = cyc + 1; g_end = cyc + 1 + d;
        done_cyc = cyc + 2 + d; b_end = cyc + 2 + d;
        idle_from = cyc + 3 + d;
        m_ptr = (w + 1) % N;
      end
    end else if (cyc >= g_start && cyc <= g_end && !bus.Req[m_w]) begin
      g_end = cyc; b_end = cyc; done_cyc = -1; idle_from = cyc + 1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    Rst = 1'b1;
    bus.Req = '0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic set_delay(input int i, input int v);
    bus.Delay[i*W +: W] = W'(v);
  endtask

  // Records (owner, length) of successive Grant runs; bounded wait.
  task automatic collect_runs(input int n, output int ridx[8], output int rlen[8]);
    int got, cur, len, budget;
    got = 0; cur = -1; len = 0; budget = 400;
    for (int i = 0; i < 8; i++) begin ridx[i] = -1; rlen[i] = -1; end
    while (got < n && budget > 0) begin
      @(negedge Clk);
      budget--;
      if (bus.Grant != '0) begin
        if (cur < 0) begin
          for (int i = 0; i < N; i++) if (bus.Grant[i]) cur = i;
          len = 1;
        end else len++;
      end else if (cur >= 0) begin
        ridx[got] = cur; rlen[got] = len; got++; cur = -1;
      end
    end
    if (got < n) check("runs_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    int ri[8], rl[8];
    Rst = 1'b1;
    bus.Req = '0;
    bus.Delay = '0;

    // Single request, delay 5; delay change mid-run must be ignored
    do_reset();
    set_delay(0, 5);
    tick();
    bus.Req = 4'b0001;
    @(negedge Clk);
    check("t1_pre_grant", 32'(bus.Grant), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("t1_grant", 32'(bus.Grant), 32'h1);
      if (i == 1) begin #1 set_delay(0, 9); end
    end
    @(negedge Clk);
    check("t1_done", 32'(bus.Done), 32'h1);
    check("t1_mo", 32'(bus.Mo), 32'h1);
    check("t1_grant_off", 32'(bus.Grant), 32'h0);
    check("t1_busy_done", 32'(bus.Busy), 32'h1);
    tick();
    bus.Req = '0;
    @(negedge Clk);
    check("t1_busy_idle", 32'(bus.Busy), 32'h0);

    // All requesting, zero delays: rotation 0,1,2,3,0
    do_reset();
    bus.Delay = '0;
    tick();
    bus.Req = 4'b1111;
    collect_runs(5, ri, rl);
    for (int k = 0; k < 5; k++) begin
      check("t2_order", 32'(ri[k]), 32'(k % 4));
      check("t2_len", 32'(rl[k]), 32'd1);
    end

    // Two requesters with different delays
    do_reset();
    set_delay(1, 3);
    set_delay(2, 1);
    tick();
    bus.Req = 4'b0110;
    collect_runs(3, ri, rl);
    check("t3_idx0", 32'(ri[0]), 32'd1); check("t3_len0", 32'(rl[0]), 32'd4);
    check("t3_idx1", 32'(ri[1]), 32'd2); check("t3_len1", 32'(rl[1]), 32'd2);
    check("t3_idx2", 32'(ri[2]), 32'd1); check("t3_len2", 32'(rl[2]), 32'd4);

    // Abort by dropping Req, then a zero-delay request
    do_reset();
    bus.Delay = '0;
    set_delay(0, 10);
    tick();
    bus.Req = 4'b0001;
    @(negedge Clk);
    repeat (4) @(negedge Clk);
    tick();
    bus.Req = '0;
    @(negedge Clk);
    check("t4_grant_last", 32'(bus.Grant), 32'h1);
    @(negedge Clk);
    check("t4_abort_grant", 32'(bus.Grant), 32'h0);
    check("t4_abort_done", 32'(bus.Done), 32'h0);
    check("t4_abort_busy", 32'(bus.Busy), 32'h0);
    @(negedge Clk);
    check("t4_no_done", 32'(bus.Done), 32'h0);
    set_delay(0, 0);
    tick();
    bus.Req = 4'b0001;
    collect_runs(1, ri, rl);
    check("t4_idx", 32'(ri[0]), 32'd0);
    check("t4_len", 32'(rl[0]), 32'd1);
    tick();
    bus.Req = '0;

    // Reset mid-run, then restart
    do_reset();
    set_delay(2, 100);
    tick();
    bus.Req = 4'b0100;
    repeat (21) @(negedge Clk);
    tick();
    Rst = 1'b1;
    bus.Req = '0;
    tick();
    @(negedge Clk);
    check("t5_rst_grant", 32'(bus.Grant), 32'h0);
    check("t5_rst_done", 32'(bus.Done), 32'h0);
    check("t5_rst_mo", 32'(bus.Mo), 32'h0);
    check("t5_rst_busy", 32'(bus.Busy), 32'h0);
    tick();
    Rst = 1'b0;
    set_delay(3, 2);
    bus.Req = 4'b1000;
    collect_runs(1, ri, rl);
    check("t5_idx3", 32'(ri[0]), 32'd3);
    check("t5_len3", 32'(rl[0]), 32'd3);
    tick();
    bus.Req = '0;
    do_reset();
    set_delay(0, 1);
    tick();
    bus.Req = 4'b1001;
    collect_runs(1, ri, rl);
    check("t5_first0", 32'(ri[0]), 32'd0);
    check("t5_len0", 32'(rl[0]), 32'd2);
    tick();
    bus.Req = '0;

`ifdef PULSO_SCHED_FIXED_PRIO_EN
    do_reset();
    bus.Delay = '0;
    tick();
    bus.Req = 4'b0011;
    collect_runs(4, ri, rl);
    for (int k = 0; k < 4; k++) check("fp_idx", 32'(ri[k]), 32'd0);
`endif

    do_reset();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
